// File: rtl/vic_regs.sv
// VIC register block: CPU-visible register file, raster counter and decoded display outputs.
// Latency: cpu_dout one cycle after a read; display outputs one cycle after a write (SHADOW=0) or frame_start (SHADOW=1).
// Backpressure: none; every CPU access and sync pulse is accepted on the cycle it is presented.
module vic_regs #(
    parameter int SHADOW = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_cs,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    input  logic        line_start,
    input  logic        frame_start,
    output logic [15:0] screen_addr,
    output logic [15:0] char_rom_addr,
    output logic [15:0] color_ram_addr,
    output logic [2:0]  border_color,
    output logic [3:0]  back_color,
    output logic        inverted,
    output logic        chars8x16,
    output logic [3:0]  aux_color,
    output logic [6:0]  xorigin,
    output logic [6:0]  yorigin,
    output logic [6:0]  rows,
    output logic [6:0]  cols,
    output logic [3:0]  volume,
    output logic [8:0]  raster
);

    typedef struct packed {
        logic [15:0] screen_addr;
        logic [15:0] char_rom_addr;
        logic [15:0] color_ram_addr;
        logic [2:0]  border_color;
        logic [3:0]  back_color;
        logic        inverted;
        logic        chars8x16;
        logic [3:0]  aux_color;
        logic [6:0]  xorigin;
        logic [6:0]  yorigin;
        logic [6:0]  rows;
        logic [6:0]  cols;
    } disp_t;

    // Power-on contents of the register file; read-only slots stay zero and are never read back.
    function automatic logic [7:0] f_preset(input logic [3:0] idx);
        case (idx)
            4'h0:    f_preset = 8'h0C;
            4'h1:    f_preset = 8'h26;
            4'h2:    f_preset = 8'h96;
            4'h3:    f_preset = 8'h2E;
            4'h5:    f_preset = 8'hF0;
            4'hF:    f_preset = 8'h1B;
            default: f_preset = 8'h00;
        endcase
    endfunction

    // Turn raw register bytes into the display-side view. VIC addresses are 14 bits;
    // the CPU sees VIC bit 13 inverted at A15 with A14:A13 forced low.
    function automatic disp_t f_decode(input logic [7:0] r0, input logic [7:0] r1,
                                       input logic [7:0] r2, input logic [7:0] r3,
                                       input logic [7:0] r5, input logic [7:0] re,
                                       input logic [7:0] rf);
        disp_t       d;
        logic [13:0] va;
        logic [13:0] vc;
        va               = {r5[7:4], r2[7], 9'b0};
        vc               = {r5[3:0], 10'b0};
        d.screen_addr    = {~va[13], 2'b00, va[12:0]};
        d.char_rom_addr  = {~vc[13], 2'b00, vc[12:0]};
        d.color_ram_addr = r2[7] ? 16'h9600 : 16'h9400;
        d.border_color   = rf[2:0];
        d.back_color     = rf[7:4];
        d.inverted       = ~rf[3];
        d.chars8x16      = r3[0];
        d.aux_color      = re[7:4];
        d.xorigin        = r0[6:0];
        d.yorigin        = r1[6:0];
        d.rows           = {1'b0, r3[6:1]};
        d.cols           = r2[6:0];
        return d;
    endfunction

    logic [7:0] r_regs [16];
    logic [7:0] w_regs_nxt [16];
    logic [8:0] r_raster;
    logic [7:0] r_dout;
    logic [7:0] w_rd_dat;
    disp_t      r_disp;
    disp_t      w_disp_nxt;
    logic       w_wr;
    logic       w_rd;

    assign w_wr = cpu_cs & cpu_we;
    assign w_rd = cpu_cs & ~cpu_we;

    // Register file as it will look after this edge; R3 bit7, R4 and R6-R9 never take writes.
    always_comb begin
        w_regs_nxt = r_regs;
        if (w_wr) begin
            case (cpu_addr)
                4'h3:                         w_regs_nxt[3] = {1'b0, cpu_din[6:0]};
                4'h4, 4'h6, 4'h7, 4'h8, 4'h9: ;
                default:                      w_regs_nxt[cpu_addr] = cpu_din;
            endcase
        end
    end

    // Read mux: raster is spliced into R3/R4, R6-R9 return fixed bus values.
    always_comb begin
        w_rd_dat = r_regs[cpu_addr];
        case (cpu_addr)
            4'h3:       w_rd_dat = {r_raster[0], r_regs[3][6:0]};
            4'h4:       w_rd_dat = r_raster[8:1];
            4'h6, 4'h7: w_rd_dat = 8'h00;
            4'h8, 4'h9: w_rd_dat = 8'hFF;
            default:    ;
        endcase
    end

    // Decode from the post-write view so a write coinciding with the load point is not lost.
    always_comb begin
        w_disp_nxt = f_decode(w_regs_nxt[0], w_regs_nxt[1], w_regs_nxt[2], w_regs_nxt[3],
                              w_regs_nxt[5], w_regs_nxt[14], w_regs_nxt[15]);
    end

    // Register file update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= f_preset(4'(i));
            end
        end else begin
            r_regs <= w_regs_nxt;
        end
    end

    // Raster counter: frame_start has priority over line_start; natural 9-bit wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_raster <= 9'd0;
        end else if (frame_start) begin
            r_raster <= 9'd0;
        end else if (line_start) begin
            r_raster <= r_raster + 9'd1;
        end
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout <= 8'h00;
        end else if (w_rd) begin
            r_dout <= w_rd_dat;
        end
    end

    // Display outputs: shadowed until frame_start, or tracking writes directly when unshadowed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp <= f_decode(8'h0C, 8'h26, 8'h96, 8'h2E, 8'hF0, 8'h00, 8'h1B);
        end else if ((SHADOW == 0) || frame_start) begin
            r_disp <= w_disp_nxt;
        end
    end

    assign cpu_dout       = r_dout;
    assign raster         = r_raster;
    assign volume         = r_regs[14][3:0];
    assign screen_addr    = r_disp.screen_addr;
    assign char_rom_addr  = r_disp.char_rom_addr;
    assign color_ram_addr = r_disp.color_ram_addr;
    assign border_color   = r_disp.border_color;
    assign back_color     = r_disp.back_color;
    assign inverted       = r_disp.inverted;
    assign chars8x16      = r_disp.chars8x16;
    assign aux_color      = r_disp.aux_color;
    assign xorigin        = r_disp.xorigin;
    assign yorigin        = r_disp.yorigin;
    assign rows           = r_disp.rows;
    assign cols           = r_disp.cols;

endmodule
